// File: rtl/rv_mdu_pkg.sv
// Shared types and helpers for the RV32M multiply/divide unit.
package rv_mdu_pkg;

    typedef enum logic [1:0] {
        DIV  = 2'b00,
        DIVU = 2'b01,
        REM  = 2'b10,
        REMU = 2'b11
    } div_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10
    } div_state_t;

    function automatic logic is_signed(div_op_t op);
        return (op == DIV) || (op == REM);
    endfunction

    function automatic logic is_rem(div_op_t op);
        return (op == REM) || (op == REMU);
    endfunction

endpackage

// File: rtl/divider_step.sv
// One radix-2 restoring iteration on {R,Q}: shift left, trial-subtract, restore on borrow.
module divider_step #(
    parameter int width = 32
) (
    input  logic [width:0]   r,
    input  logic [width-1:0] q,
    input  logic [width-1:0] d,
    output logic [width:0]   r_next,
    output logic [width-1:0] q_next
);

    logic [width+1:0] shifted;
    logic [width+1:0] diff;

    assign shifted = {r, q[width-1]};
    assign diff    = shifted - {2'b00, d};

    always_comb begin
        if (diff[width+1]) begin
            r_next = shifted[width:0];
            q_next = {q[width-2:0], 1'b0};
        end else begin
            r_next = diff[width:0];
            q_next = {q[width-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/divider.sv
// Multi-cycle restoring divider for RV32M (DIV/DIVU/REM/REMU) with start/busy/done handshake.
// Optional macro DIVIDER_EARLY_OUT_EN: single-cycle result when |a| < |b|.
//
//   state | meaning
//   IDLE  | waiting for start; divide-by-zero/overflow/early-out resolved here
//   CALC  | one restoring iteration per cycle, cnt_q counts down to 0
//   FIX   | sign correction, result registered, done pulsed
module divider
    import rv_mdu_pkg::*;
#(
    parameter int width = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [width-1:0] a,
    input  logic [width-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [width-1:0] result
);

    localparam int cw = $clog2(width) + 1;

    div_state_t       state, state_nxt;
    logic [width:0]   rem_q, rem_step;
    logic [width-1:0] quo_q, quo_step, dmag_q;
    div_op_t          op_q, op_in;
    logic             sa_q, sb_q;
    logic [cw-1:0]    cnt_q;

    logic             sa_in, sb_in;
    logic [width-1:0] amag, bmag;
    logic             div0, ovf, early, fast;
    logic [width-1:0] fast_res, quo_fix, rem_fix;

    assign op_in = div_op_t'(op);
    assign sa_in = is_signed(op_in) & a[width-1];
    assign sb_in = is_signed(op_in) & b[width-1];
    assign amag  = sa_in ? -a : a;
    assign bmag  = sb_in ? -b : b;

    assign div0 = (b == '0);
    assign ovf  = is_signed(op_in) && (a == {1'b1, {(width-1){1'b0}}}) && (b == '1);
`ifdef DIVIDER_EARLY_OUT_EN
    assign early = !div0 && (amag < bmag);
`else
    assign early = 1'b0;
`endif
    assign fast = div0 | ovf | early;

    // Divide-by-zero takes priority; early-out returns a untouched as the remainder.
    always_comb begin
        fast_res = '0;
        if (div0)
            fast_res = is_rem(op_in) ? a : '1;
        else if (ovf)
            fast_res = is_rem(op_in) ? '0 : a;
        else
            fast_res = is_rem(op_in) ? a : '0;
    end

    assign quo_fix = (sa_q ^ sb_q) ? -quo_q : quo_q;
    assign rem_fix = sa_q ? -rem_q[width-1:0] : rem_q[width-1:0];

    divider_step #(.width(width)) u_step (
        .r      (rem_q),
        .q      (quo_q),
        .d      (dmag_q),
        .r_next (rem_step),
        .q_next (quo_step)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start && !fast) state_nxt = CALC;
            CALC:    if (cnt_q == '0) state_nxt = FIX;
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_q  <= '0;
            quo_q  <= '0;
            dmag_q <= '0;
            op_q   <= DIV;
            sa_q   <= 1'b0;
            sb_q   <= 1'b0;
            cnt_q  <= '0;
            result <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (fast) begin
                            result <= fast_res;
                            done   <= 1'b1;
                        end else begin
                            rem_q  <= '0;
                            quo_q  <= amag;
                            dmag_q <= bmag;
                            op_q   <= op_in;
                            sa_q   <= sa_in;
                            sb_q   <= sb_in;
                            cnt_q  <= cw'(width - 1);
                        end
                    end
                end
                CALC: begin
                    rem_q <= rem_step;
                    quo_q <= quo_step;
                    if (cnt_q != '0)
                        cnt_q <= cnt_q - cw'(1);
                end
                FIX: begin
                    result <= is_rem(op_q) ? rem_fix : quo_fix;
                    done   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/divider.md
# divider

Multi-cycle radix-2 restoring integer divider that completes the RV32M datapath alongside the combinational Wallace-tree multiplier. Implements DIV, DIVU, REM and REMU with full RISC-V corner-case semantics. Uses a start/busy/done handshake so the execute stage can stall while an operation is in flight.

## Interface
- `width`, 32, operand and result width in bits.

- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: request a new operation. Sampled only while the block is idle.
- `op` in 2: operation select: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- `a` in width: dividend (rs1).
- `b` in width: divisor (rs2).
- `busy` out 1: high while an operation is in flight.
- `done` out 1: single-cycle pulse; `result` is valid in that cycle.
- `result` out width: quotient or remainder, held until the next accepted start.

## Operation
- States:
  - IDLE: accepts `start`.
  - CALC: width iterations.
  - FIX: sign correction; registers `result` and pulses `done`.
- On accept, the block latches magnitudes |a| and |b|; signed ops take the two's-complement absolute value.
  - It also latches `op`, sign(a) and sign(b), so input changes after accept have no effect.
- CALC iteration, on a width+1-bit partial remainder R and a width-bit quotient Q:
  - Shift {R,Q} left by one.
  - Trial-subtract the divisor magnitude from R.
  - If the result is non-negative, keep it and set Q[0]=1; otherwise restore R.
- FIX applies the sign rules, then returns to IDLE:
  - Quotient is negated if signed and sign(a)≠sign(b).
  - Remainder is negated if signed and sign(a)=1.
  - The remainder is R[width-1:0].
- Special cases are resolved at accept: `result` is registered and `done` pulses immediately, with no CALC.
  - Divide by zero (b=0): quotient all ones, remainder = a, for signed and unsigned.
  - Signed overflow (a=100…0, b=all ones, op DIV/REM): quotient = a, remainder = 0.
- `start` while busy is ignored and does not queue.
- `start` in the same cycle `done` is high is accepted, giving back-to-back operations.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `result`=0, all internal registers 0.
- Normal latency: `start` sampled high at edge N.
  - `busy` is high after edge N.
  - CALC runs over edges N+1..N+width.
  - FIX occurs at edge N+width+1, after which `done`=1, `busy`=0 and `result` is valid: width+1 cycles (33 at default).
- Special-case latency: `done`=1 after edge N (1 cycle); `busy` never rises.
- `done` is high for exactly one cycle. `result` stays stable until the next accepted `start` updates it.
- Reset mid-operation: the block returns to IDLE immediately and asynchronously, with outputs at reset values and no `done` pulse. The operation is lost.

## Configuration
- Macro `DIVIDER_EARLY_OUT_EN`.
  - Defined: at accept, if |a| < |b| (unsigned magnitude compare, b≠0), the block takes the fast path.
    - Quotient result = 0; remainder result = a, unmodified.
    - `done` after 1 cycle, with no CALC.
  - Undefined: such operands take the full width+1 latency. Results are identical.
- The divide-by-zero and overflow fast paths are always present.

## Structure
- Shared package `rv_mdu_pkg` holds:
  - The `div_op_t` enum: DIV, DIVU, REM, REMU.
  - The `div_state_t` enum: IDLE, CALC, FIX.
  - Helper functions `is_signed(op)` and `is_rem(op)`.
- Sub-module `divider_step` is combinational and holds one restoring iteration.
  - Inputs: {R,Q} and the divisor magnitude.
  - Outputs: next {R,Q}.
  - The bench can unit-test it in isolation.
- The iteration counter is clog2(width)+1 bits, counts down from width-1, and leaves CALC at 0.

## Test plan
- DIVU: a=100, b=7 → `done` 33 cycles after start, `result`=14. Repeat with REMU → 2.
- DIV: a=-100 (0xFFFFFF9C), b=7 → `result`=0xFFFFFFF2 (-14). REM → 0xFFFFFFFE (-2). Also REM with a=100, b=-7 → 2.
- Divide by zero:
  - DIV a=5, b=0 → 0xFFFFFFFF after 1 cycle.
  - REMU a=5, b=0 → 5.
  - `busy` stays 0 throughout.
- Overflow:
  - DIV a=0x80000000, b=0xFFFFFFFF → 0x80000000 after 1 cycle.
  - REM with the same operands → 0.
- Handshake:
  - Pulse `start` again mid-CALC → ignored, and the first result is unchanged.
  - Assert `start` in the `done` cycle → a second `done` arrives exactly 33 cycles later.
  - Assert `rst` at cycle 10 of CALC → `busy`=0, `result`=0 and no `done` pulse.
- With `DIVIDER_EARLY_OUT_EN` defined: DIVU a=3, b=10 → `result`=0 after 1 cycle; REMU → 3. Without the macro, the same values arrive after 33 cycles.
